// File: rtl/instr_fetch_if.sv
// Bundle of fetch-unit control, redirect, memory and presentation signals.
// master: the surrounding pipeline/memory side; slave: the fetch unit.
interface instr_fetch_if;
    logic       start;
    logic [9:0] start_addr;
    logic       stall;
    logic       branch;
    logic       zero;
    logic [1:0] jump;
    logic [7:0] branch_off;
    logic [9:0] jump_target;
    logic [9:0] reg_target;
    logic       halt_req;
    logic [9:0] imem_addr;
    logic [8:0] imem_rdata;
    logic [8:0] instr;
    logic [5:0] op;
    logic [9:0] instr_pc;
    logic       instr_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, start_addr, stall, branch, zero, jump, branch_off,
               jump_target, reg_target, halt_req, imem_rdata,
        input  imem_addr, instr, op, instr_pc, instr_valid, busy, done
    );

    modport slave (
        input  start, start_addr, stall, branch, zero, jump, branch_off,
               jump_target, reg_target, halt_req, imem_rdata,
        output imem_addr, instr, op, instr_pc, instr_valid, busy, done
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC stage, in-flight memory read, presented word.
// A one-entry skid register catches the in-flight word when the consumer
// stalls, so the PC can simply be re-driven and no word is lost.
//
// state  | meaning
// S_IDLE | out of reset, waiting for start
// S_RUN  | fetching and presenting instructions
// S_DONE | halt accepted, pc frozen, waiting for start
module instr_fetch (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [9:0] r_pc;
    logic       r_pc_v;
    logic [9:0] r_f_pc;
    logic       r_f_v;
    logic [8:0] r_skid;
    logic [9:0] r_skid_pc;
    logic       r_skid_v;
    logic [8:0] r_instr;
    logic [9:0] r_instr_pc;
    logic       r_instr_valid;

    logic       w_start;
    logic       w_accept;
    logic       w_halt;
    logic       w_hold;
    logic       w_redirect;
    logic       w_take;
    logic [9:0] w_target;
    logic [9:0] w_br_target;

    assign w_start     = bus.start & (r_state != S_RUN);
    assign w_accept    = r_instr_valid & ~bus.stall & (r_state == S_RUN);
    assign w_halt      = w_accept & bus.halt_req;
    assign w_hold      = r_instr_valid & bus.stall;
    assign w_take      = w_accept & w_redirect & ~bus.halt_req;
    assign w_br_target = r_instr_pc + {{2{bus.branch_off[7]}}, bus.branch_off};

    // Redirect target selection; jump=10 is illegal and never redirects.
    always_comb begin
        w_redirect = 1'b0;
        w_target   = '0;
        case (bus.jump)
            2'b01: begin
                w_redirect = 1'b1;
                w_target   = bus.jump_target;
            end
            2'b11: begin
                w_redirect = 1'b1;
                w_target   = bus.reg_target;
            end
            2'b00: begin
                if (bus.branch & bus.zero) begin
                    w_redirect = 1'b1;
                    w_target   = w_br_target;
                end
            end
            default: begin
                w_redirect = 1'b0;
                w_target   = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_halt)  w_state_nxt = S_DONE;
            S_DONE:  if (w_start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pipeline datapath: PC, in-flight read, skid and presented stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_pc_v        <= 1'b0;
            r_f_pc        <= '0;
            r_f_v         <= 1'b0;
            r_skid        <= '0;
            r_skid_pc     <= '0;
            r_skid_v      <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (w_start) begin
            r_pc          <= bus.start_addr;
            r_pc_v        <= 1'b1;
            r_f_v         <= 1'b0;
            r_skid_v      <= 1'b0;
            r_instr_valid <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_halt) begin
                r_pc_v        <= 1'b0;
                r_f_v         <= 1'b0;
                r_skid_v      <= 1'b0;
                r_instr_valid <= 1'b0;
            end else if (w_take) begin
                r_pc          <= w_target;
                r_pc_v        <= 1'b1;
                r_f_v         <= 1'b0;
                r_skid_v      <= 1'b0;
                r_instr_valid <= 1'b0;
            end else if (w_hold) begin
                // PC is held and re-driven; the word returning now is the
                // successor of the presented one, so park it once.
                r_f_pc <= r_pc;
                r_f_v  <= r_pc_v;
                if (!r_skid_v) begin
                    r_skid    <= bus.imem_rdata;
                    r_skid_pc <= r_f_pc;
                    r_skid_v  <= r_f_v;
                end
            end else begin
                r_f_pc <= r_pc;
                r_f_v  <= r_pc_v;
                if (r_pc_v) r_pc <= r_pc + 10'd1;
                if (r_skid_v) begin
                    r_instr       <= r_skid;
                    r_instr_pc    <= r_skid_pc;
                    r_instr_valid <= 1'b1;
                    r_skid_v      <= 1'b0;
                end else begin
                    r_instr_valid <= r_f_v;
                    if (r_f_v) begin
                        r_instr    <= bus.imem_rdata;
                        r_instr_pc <= r_f_pc;
                    end
                end
            end
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.op          = r_instr[8:3];
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a registered instruction memory model.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [8:0] mem [1024];

    instr_fetch_if bus_if ();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Memory returns the word one cycle after its address is driven.
    always @(posedge clk) bus_if.imem_rdata <= mem[bus_if.imem_addr];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_present(input string tag, input logic [9:0] pc);
        chk_eq({tag, "_valid"}, 32'(bus_if.instr_valid), 32'd1);
        chk_eq({tag, "_pc"},    32'(bus_if.instr_pc),    32'(pc));
        chk_eq({tag, "_instr"}, 32'(bus_if.instr),       32'(mem[pc]));
    endtask

    task automatic chk_reset_state(input string tag);
        chk_eq({tag, "_valid"}, 32'(bus_if.instr_valid), 32'd0);
        chk_eq({tag, "_busy"},  32'(bus_if.busy),        32'd0);
        chk_eq({tag, "_done"},  32'(bus_if.done),        32'd0);
        chk_eq({tag, "_addr"},  32'(bus_if.imem_addr),   32'd0);
        chk_eq({tag, "_instr"}, 32'(bus_if.instr),       32'd0);
        chk_eq({tag, "_ipc"},   32'(bus_if.instr_pc),    32'd0);
    endtask

    task automatic wait_pc(input logic [9:0] pc);
        int n = 0;
        while (!(bus_if.instr_valid === 1'b1 && bus_if.instr_pc === pc) && n < 64) begin
            tick();
            n++;
        end
        chk_eq("reach_pc", {21'd0, bus_if.instr_valid, bus_if.instr_pc}, {21'd0, 1'b1, pc});
    endtask

    task automatic clr_redirect();
        bus_if.branch      = 1'b0;
        bus_if.zero        = 1'b0;
        bus_if.jump        = 2'b00;
        bus_if.branch_off  = 8'h00;
        bus_if.jump_target = 10'h000;
        bus_if.reg_target  = 10'h000;
        bus_if.halt_req    = 1'b0;
    endtask

    // Absolute jump from the presented word, landing after two bubbles.
    task automatic jump_to(input logic [9:0] tgt);
        bus_if.jump        = 2'b01;
        bus_if.jump_target = tgt;
        tick();
        clr_redirect();
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 9'((i * 5 + 1) & 511);
        mem[10'h010] = 9'h041;
        mem[10'h011] = 9'h042;
        mem[10'h012] = 9'h043;
        mem[10'h013] = 9'h044;

        reset             = 1'b1;
        bus_if.start      = 1'b0;
        bus_if.start_addr = 10'h000;
        bus_if.stall      = 1'b0;
        clr_redirect();
        tick();
        tick();
        chk_reset_state("rst");

        // Linear fetch
        reset             = 1'b0;
        bus_if.start      = 1'b1;
        bus_if.start_addr = 10'h010;
        tick();
        bus_if.start = 1'b0;
        chk_eq("lin_busy", 32'(bus_if.busy), 32'd1);
        chk_eq("lin_c1_valid", 32'(bus_if.instr_valid), 32'd0);
        tick();
        chk_eq("lin_c2_valid", 32'(bus_if.instr_valid), 32'd0);
        tick();
        chk_present("lin0", 10'h010);
        chk_eq("lin0_op", 32'(bus_if.op), 32'h08);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk_present("lin", 10'(10'h010 + k));
        end

        // Taken branch backwards with a stall during a bubble (ignored)
        wait_pc(10'h020);
        bus_if.branch     = 1'b1;
        bus_if.zero       = 1'b1;
        bus_if.branch_off = 8'hFC;
        tick();
        clr_redirect();
        chk_eq("br_bub1", 32'(bus_if.instr_valid), 32'd0);
        bus_if.stall = 1'b1;
        tick();
        bus_if.stall = 1'b0;
        chk_eq("br_bub2", 32'(bus_if.instr_valid), 32'd0);
        tick();
        chk_present("br_tgt", 10'h01C);

        // Not-taken branch
        wait_pc(10'h020);
        bus_if.branch     = 1'b1;
        bus_if.zero       = 1'b0;
        bus_if.branch_off = 8'hFC;
        tick();
        clr_redirect();
        chk_present("br_nt", 10'h021);

        // Register jump beats absolute target and branch, then wrap
        bus_if.jump        = 2'b11;
        bus_if.reg_target  = 10'h3FF;
        bus_if.jump_target = 10'h155;
        bus_if.branch      = 1'b1;
        bus_if.zero        = 1'b1;
        bus_if.branch_off  = 8'h10;
        tick();
        clr_redirect();
        tick();
        tick();
        chk_present("jr_tgt", 10'h3FF);
        tick();
        chk_present("jr_wrap", 10'h000);

        // Absolute jump beats branch
        bus_if.branch     = 1'b1;
        bus_if.zero       = 1'b1;
        bus_if.branch_off = 8'h40;
        jump_to(10'h200);
        chk_present("ja_tgt", 10'h200);

        // Illegal jump encoding: no redirect, no bubble
        bus_if.jump        = 2'b10;
        bus_if.jump_target = 10'h111;
        bus_if.reg_target  = 10'h222;
        tick();
        clr_redirect();
        chk_present("jill", 10'h201);

        // Stall for three cycles on 0x005
        jump_to(10'h005);
        chk_present("st_pre", 10'h005);
        bus_if.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_present("st_hold", 10'h005);
        end
        chk_eq("st_addr", 32'(bus_if.imem_addr), 32'h007);
        bus_if.stall = 1'b0;
        tick();
        chk_present("st_rel1", 10'h006);
        tick();
        chk_present("st_rel2", 10'h007);
        tick();
        chk_present("st_rel3", 10'h008);

        // Halt and restart
        jump_to(10'h030);
        chk_present("ht_pre", 10'h030);
        bus_if.halt_req = 1'b1;
        tick();
        bus_if.halt_req = 1'b0;
        chk_eq("ht_done",  32'(bus_if.done),        32'd1);
        chk_eq("ht_busy",  32'(bus_if.busy),        32'd0);
        chk_eq("ht_valid", 32'(bus_if.instr_valid), 32'd0);
        tick();
        chk_eq("ht_stay", 32'(bus_if.done), 32'd1);
        bus_if.start      = 1'b1;
        bus_if.start_addr = 10'h100;
        tick();
        bus_if.start = 1'b0;
        chk_eq("rs_busy", 32'(bus_if.busy), 32'd1);
        chk_eq("rs_done", 32'(bus_if.done), 32'd0);
        tick();
        tick();
        chk_present("rs_first", 10'h100);
        tick();
        chk_present("rs_next", 10'h101);

        // Reset while stalled with the skid full, start asserted too
        bus_if.stall = 1'b1;
        tick();
        tick();
        chk_present("rr_hold", 10'h101);
        reset             = 1'b1;
        bus_if.start      = 1'b1;
        bus_if.start_addr = 10'h2AA;
        tick();
        chk_reset_state("rr");
        reset             = 1'b0;
        bus_if.stall      = 1'b0;
        bus_if.start_addr = 10'h3FE;
        tick();
        bus_if.start = 1'b0;
        tick();
        tick();
        chk_present("rr_first", 10'h3FE);
        tick();
        chk_present("rr_next", 10'h3FF);
        tick();
        chk_present("rr_wrap", 10'h000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
